// File: rtl/fdiv32_iter.sv
// fdiv32_iter - iterative single-precision IEEE-754 divider (result = op1 / op2).
//
// A radix-2 restoring divider produces 26 quotient bits, one per cycle, under a
// five-state FSM. Denormal operands are treated as zero; results that would be
// denormal are flushed to signed zero. Four rounding modes are supported.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, accepted only in IDLE; op1/op2/rmode sampled with it
//   op1, op2    : dividend, divisor
//   rmode       : 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   busy        : high from the cycle after accept until the result cycle
//   val         : one-cycle pulse, result/dz/inv valid
//   result      : quotient, held until the next completion
//   dz, inv     : divide-by-zero / invalid flags, qualified by val
//
// Handshake: start is a request sampled on a rising edge while the FSM is in
// IDLE; there is no back-pressure, and the single val pulse marks completion.
// Starts seen outside IDLE are dropped without side effects.

module fdiv32_iter #(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000,
  parameter int          QBITS     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [1:0]  rmode,
  output logic        busy,
  output logic        val,
  output logic [31:0] result,
  output logic        dz,
  output logic        inv
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_ROUND, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         a_q, a_d, b_q, b_d;
  logic [1:0]          rmode_q, rmode_d;
  logic                sign_q, sign_d;
  logic signed [9:0]   exp_q, exp_d;
  logic [24:0]         rem_q, rem_d;
  logic [23:0]         div_q, div_d;
  // The integer quotient bit is always 1 and is shifted out of this 25-bit
  // register; after the last step it holds mantissa[24:2], guard[1], round[0].
  logic [24:0]         quo_q, quo_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         result_q, result_d;
  logic                dz_q, dz_d, inv_q, inv_d, val_q, val_d, busy_q, busy_d;

  // Operand classification (denormals count as zero).
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [23:0] m1, m2;
  logic signed [9:0] exp_c;

  assign a_zero = (a_q[30:23] == 8'h00);
  assign b_zero = (b_q[30:23] == 8'h00);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
  assign m1     = {1'b1, a_q[22:0]};
  assign m2     = {1'b1, b_q[22:0]};
  assign exp_c  = $signed({2'b00, a_q[30:23]} - {2'b00, b_q[30:23]} + 10'd127);

  // Divide step and rounding helpers.
  logic        step_ge;
  logic [24:0] step_rem;
  logic        sticky, inc;
  logic [23:0] mant_sum;
  logic signed [9:0] exp_r;

  assign step_ge  = (rem_q >= {1'b0, div_q});
  assign step_rem = step_ge ? (rem_q - {1'b0, div_q}) : rem_q;
  assign sticky   = |rem_q;
  assign mant_sum = {1'b0, quo_q[24:2]} + {23'h0, inc};
  assign exp_r    = exp_q + $signed({9'h0, mant_sum[23]});

  always_comb begin
    unique case (rmode_q)
      2'b00:   inc = quo_q[1] & (quo_q[0] | sticky | quo_q[2]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~sign_q & (quo_q[1] | quo_q[0] | sticky);
      default: inc =  sign_q & (quo_q[1] | quo_q[0] | sticky);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rmode_d  = rmode_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
    inv_d    = inv_q;
    val_d    = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op1;
          b_d     = op2;
          rmode_d = rmode;
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        sign_d = a_q[31] ^ b_q[31];
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = CANON_NAN;
          inv_d    = 1'b1;
        end else if (b_zero) begin
          result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
          dz_d     = 1'b1;
        end else if (a_inf) begin
          result_d = {a_q[31] ^ b_q[31], 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
          result_d = {a_q[31] ^ b_q[31], 31'h0};
        end

        if (a_nan || b_nan || a_zero || b_zero || a_inf || b_inf) begin
          val_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          // Pre-normalise so the quotient lands in [1,2).
          if (m1 < m2) begin
            rem_d = {m1, 1'b0};
            exp_d = exp_c - 10'sd1;
          end else begin
            rem_d = {1'b0, m1};
            exp_d = exp_c;
          end
          div_d   = m2;
          quo_d   = 25'h0;
          cnt_d   = 5'd0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        // step_rem < divisor < 2^24, so the shift never loses a bit.
        rem_d = {step_rem[23:0], 1'b0};
        quo_d = {quo_q[23:0], step_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(QBITS - 1)) state_d = S_ROUND;
      end

      S_ROUND: begin
        if (exp_r >= 10'sd255) begin
          unique case (rmode_q)
            2'b00:   result_d = {sign_q, 8'hFF, 23'h0};
            2'b01:   result_d = {sign_q, 31'h7F7F_FFFF};
            2'b10:   result_d = sign_q ? {sign_q, 31'h7F7F_FFFF} : {sign_q, 8'hFF, 23'h0};
            default: result_d = sign_q ? {sign_q, 8'hFF, 23'h0} : {sign_q, 31'h7F7F_FFFF};
          endcase
        end else if (exp_r <= 10'sd0) begin
          result_d = {sign_q, 31'h0};
        end else begin
          // On mantissa carry-out mant_sum[22:0] is already zero.
          result_d = {sign_q, exp_r[7:0], mant_sum[22:0]};
        end
        val_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      rmode_q  <= 2'b00;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      rem_q    <= 25'h0;
      div_q    <= 24'h0;
      quo_q    <= 25'h0;
      cnt_q    <= 5'd0;
      result_q <= 32'h0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rmode_q  <= rmode_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      inv_q    <= inv_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign val    = val_q;
  assign result = result_q;
  assign dz     = dz_q;
  assign inv    = inv_q;

endmodule
